fme_mux_sequencer: RTL and testbench
====================================

# fme_mux_sequencer

Sequencer for the fractional motion estimation (FME) candidate-row multiplexer.
- The downstream 3:1 mux takes three 16-sample groups: integer-pel, half-pel and quarter-pel.
- On each start, this block drives the mux selects c1/c0 and emits a valid/ready beat stream, one beat per block row, over each group in turn.
- It closes the pass with a single-cycle done pulse.
- It sits between the FME top-level control and the mux/SAD datapath.

## Interface
- ROWS, 4, rows per candidate group (beats per group); legal range ≥ 2.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  pass request; sampled only in IDLE.
- half_only  in  1  mode, sampled with start: 1 skips the quarter-pel group.
- out_ready  in  1  downstream accepts the current beat.
- abort  in  1  only present when FME_SEQ_ABORT_EN is defined.
- c1  out  1  mux select, high bit.
- c0  out  1  mux select, low bit.
- out_valid  out  1  current beat (select plus row_idx) is valid.
- row_idx  out  $clog2(ROWS)  row index within the current group.
- grp_idx  out  2  0 = integer, 1 = half, 2 = quarter.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the pass completes.

## Operation
- FSM states:
  - IDLE: outputs 00, out_valid 0.
  - RUN_INT: c1c0 = 00, grp_idx 0.
  - RUN_HALF: c1c0 = 10, grp_idx 1.
  - RUN_QUART: c1c0 = 11, grp_idx 2.
  - DONE.
- Selects are registered from the state; select 01 is never driven.
- IDLE → RUN_INT when start = 1; half_only is latched into a mode flag at the same edge.
- Transfer occurs when out_valid and out_ready are both high. On a transfer, row_idx increments.
- On a transfer with row_idx = ROWS−1:
  - row_idx wraps to 0 and the state advances.
  - RUN_INT → RUN_HALF.
  - RUN_HALF → RUN_QUART, or RUN_HALF → DONE if the mode flag is set.
  - RUN_QUART → DONE.
- DONE lasts one cycle with done = 1, then returns to IDLE.
- start is ignored while busy; no queuing. start arriving in the DONE cycle is dropped.
- While out_ready = 0, all outputs hold their values.
- half_only changes mid-pass have no effect.
- Reset values: state IDLE; c1, c0, out_valid, busy and done all 0; row_idx 0; grp_idx 0; mode flag 0.
- Reset mid-pass returns to IDLE immediately. No done pulse is issued.

## Timing
- Start latency: start sampled at edge N → out_valid = 1, c1c0 = 00, row_idx = 0 from edge N+1.
- With out_ready held high:
  - Full pass: 3·ROWS beats, with done high during cycle N+3·ROWS+1.
  - Half-only pass: 2·ROWS beats, with done high during cycle N+2·ROWS+1.
- The group boundary adds no bubble: the beat after the last row of a group is row 0 of the next group on the following cycle.
- done and out_valid are never high in the same cycle.
- No combinational path from any input to any output.

## Configuration
- FME_SEQ_ABORT_EN defined:
  - The abort port exists.
  - abort = 1 at an edge in any RUN state or DONE → next state IDLE, row_idx 0, mode flag 0, no done pulse.
  - abort in IDLE has priority over start; the start is ignored.
  - abort has priority over a simultaneous transfer.
- FME_SEQ_ABORT_EN undefined: no abort port; passes always run to DONE unless reset.

## Structure
- Package fme_seq_pkg holds:
  - The state enum: IDLE, RUN_INT, RUN_HALF, RUN_QUART, DONE.
  - Select constants SEL_INT = 2'b00, SEL_HALF = 2'b10, SEL_QUART = 2'b11.
  - Group index constants.
- One sub-module, fme_beat_counter:
  - Parameterised modulo-ROWS counter with enable and clear.
  - Outputs the count and a last (terminal) flag.
- The FSM, mode latch and output registers live in fme_mux_sequencer.

## Test plan
- Reset, ROWS = 4, out_ready = 1, start pulse with half_only = 0 → 12 beats with c1c0 = 00×4, 10×4, 11×4 and row_idx 0..3 in each group; done in cycle 13 after start; busy falls after done.
- half_only = 1 → 8 beats (00×4, 10×4), done in cycle 9; select 11 never appears.
- out_ready toggled 1,0,0,1… → outputs stable while stalled; exactly 12 transfers; done follows the final transfer by one cycle.
- start re-asserted during RUN_HALF and in the DONE cycle → ignored; a second start in IDLE begins a fresh pass at row 0, 00.
- rst_n asserted mid-RUN_QUART → all outputs 0 asynchronously, no done pulse; a normal pass works after release.
- FME_SEQ_ABORT_EN: abort at row 2 of RUN_HALF → IDLE next cycle, done stays 0; abort together with start in IDLE → stays IDLE.

Source files
------------

// File: rtl/fme_seq_pkg.sv
// Shared types and constants for the FME candidate-row mux sequencer.
package fme_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN_INT,
    RUN_HALF,
    RUN_QUART,
    DONE
  } state_t;

  localparam logic [1:0] SEL_INT   = 2'b00;
  localparam logic [1:0] SEL_HALF  = 2'b10;
  localparam logic [1:0] SEL_QUART = 2'b11;

  localparam logic [1:0] GRP_INT   = 2'd0;
  localparam logic [1:0] GRP_HALF  = 2'd1;
  localparam logic [1:0] GRP_QUART = 2'd2;

  typedef struct packed {
    logic [1:0] sel;
    logic       valid;
    logic [1:0] grp;
    logic       busy;
    logic       done;
  } seq_out_t;

  // Output image of a state; registered by the top so outputs never see inputs combinationally.
  function automatic seq_out_t decode(state_t s);
    seq_out_t o;
    o = '0;
    case (s)
      RUN_INT:   begin o.sel = SEL_INT;   o.grp = GRP_INT;   o.valid = 1'b1; o.busy = 1'b1; end
      RUN_HALF:  begin o.sel = SEL_HALF;  o.grp = GRP_HALF;  o.valid = 1'b1; o.busy = 1'b1; end
      RUN_QUART: begin o.sel = SEL_QUART; o.grp = GRP_QUART; o.valid = 1'b1; o.busy = 1'b1; end
      DONE:      begin o.busy = 1'b1; o.done = 1'b1; end
      default:   o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/fme_beat_counter.sv
// Modulo-ROWS beat counter with enable and synchronous clear; last flags the terminal count.
module fme_beat_counter #(
  parameter int ROWS = 4,
  parameter int W    = $clog2(ROWS)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         last
);

  assign last = (count == W'(ROWS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   count <= '0;
    else if (clr) count <= '0;
    else if (en)  count <= last ? '0 : count + 1'b1;
  end

endmodule

// File: rtl/fme_mux_sequencer.sv
// FME 3:1 candidate mux sequencer: walks integer/half/quarter groups, one beat per row.
// Optional abort input enabled by defining FME_SEQ_ABORT_EN.
module fme_mux_sequencer
  import fme_seq_pkg::*;
#(
  parameter int ROWS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    half_only,
  input  logic                    out_ready,
`ifdef FME_SEQ_ABORT_EN
  input  logic                    abort,
`endif
  output logic                    c1,
  output logic                    c0,
  output logic                    out_valid,
  output logic [$clog2(ROWS)-1:0] row_idx,
  output logic [1:0]              grp_idx,
  output logic                    busy,
  output logic                    done
);

  state_t   state, state_d;
  seq_out_t out_d;
  logic     mode;
  logic     xfer, last, abort_i;

`ifdef FME_SEQ_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  assign xfer = out_valid & out_ready;

  fme_beat_counter #(.ROWS(ROWS)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (xfer),
    .clr   (abort_i),
    .count (row_idx),
    .last  (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:      if (start)       state_d = RUN_INT;
      RUN_INT:   if (xfer && last) state_d = RUN_HALF;
      RUN_HALF:  if (xfer && last) state_d = mode ? DONE : RUN_QUART;
      RUN_QUART: if (xfer && last) state_d = DONE;
      DONE:                        state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
    if (abort_i) state_d = IDLE;
  end

  always_comb begin
    out_d = decode(state_d);
  end

  // Mode is captured only at pass launch, so half_only is don't-care mid-pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      mode <= 1'b0;
    else if (abort_i)                mode <= 1'b0;
    else if (state == IDLE && start) mode <= half_only;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c1        <= 1'b0;
      c0        <= 1'b0;
      out_valid <= 1'b0;
      grp_idx   <= GRP_INT;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      c1        <= out_d.sel[1];
      c0        <= out_d.sel[0];
      out_valid <= out_d.valid;
      grp_idx   <= out_d.grp;
      busy      <= out_d.busy;
      done      <= out_d.done;
    end
  end

endmodule

// File: tb/tb_fme_mux_sequencer.sv
// Scoreboard bench for fme_mux_sequencer: stimulus pushes expected beats, a monitor pops on transfer.
module tb_fme_mux_sequencer;

  localparam int ROWS = 4;
  localparam int RW   = $clog2(ROWS);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          half_only = 1'b0;
  logic          out_ready = 1'b0;
  logic          abort = 1'b0;
  logic          c1, c0, out_valid, busy, done;
  logic [RW-1:0] row_idx;
  logic [1:0]    grp_idx;

  int total = 0;
  int bad   = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  fme_mux_sequencer #(.ROWS(ROWS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .half_only (half_only),
    .out_ready (out_ready),
`ifdef FME_SEQ_ABORT_EN
    .abort     (abort),
`endif
    .c1        (c1),
    .c0        (c0),
    .out_valid (out_valid),
    .row_idx   (row_idx),
    .grp_idx   (grp_idx),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int beat_code(input int sel, input int row, input int grp);
    return (sel << (RW + 2)) | (row << 2) | grp;
  endfunction

  function automatic int cur_code();
    return beat_code({c1, c0}, row_idx, grp_idx);
  endfunction

  // Monitor: pops on every presented-and-accepted beat, checks hold-while-stalled.
  int  prev_code;
  bit  prev_stall = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (done && out_valid) chk("done_with_valid", 1, 0);
      if (prev_stall) chk("stall_hold", {out_valid, cur_code()}, {1'b1, prev_code});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_beat", cur_code(), -1);
        else chk("beat", cur_code(), exp_q.pop_front());
      end
      prev_stall = out_valid && !out_ready;
      prev_code  = cur_code();
    end else begin
      prev_stall = 0;
    end
  end

  task automatic chk_idle(input string name);
    chk({name, "_c1c0"},  {c1, c0}, 0);
    chk({name, "_valid"}, out_valid, 0);
    chk({name, "_busy"},  busy, 0);
    chk({name, "_done"},  done, 0);
    chk({name, "_row"},   row_idx, 0);
    chk({name, "_grp"},   grp_idx, 0);
  endtask

  task automatic push_pass(input logic ho);
    int sels[3];
    sels[0] = 0; sels[1] = 2; sels[2] = 3;
    for (int g = 0; g < (ho ? 2 : 3); g++)
      for (int r = 0; r < ROWS; r++) exp_q.push_back(beat_code(sels[g], r, g));
  endtask

  // One pass; toggle drives out_ready 1,0,0,1...; re_half/re_done re-assert start mid-pass / at done.
  task automatic run_pass(input logic ho, input bit toggle, input bit re_half, input bit re_done);
    int edges = 0;
    int ph = 0;
    bit seen = 0;
    bit pat[4];
    pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1;
    push_pass(ho);
    start = 1; half_only = ho; out_ready = 1;
    @(posedge clk); #1;
    start = 0; half_only = ~ho;
    chk("launch_beat0", {out_valid, cur_code()}, {1'b1, beat_code(0, 0, 0)});
    while (!seen && edges < 200) begin
      if (done) seen = 1;
      else begin
        start     = re_half && grp_idx == 2'd1 && row_idx == 1;
        out_ready = toggle ? pat[ph % 4] : 1'b1;
        ph++;
        @(posedge clk); #1;
        edges++;
      end
    end
    start = 0;
    if (!seen) begin
      chk("done_timeout", 0, 1);
      exp_q.delete();
      return;
    end
    if (!toggle) chk("done_latency", edges, ho ? 2 * ROWS : 3 * ROWS);
    chk("queue_empty_at_done", exp_q.size(), 0);
    chk("busy_at_done", busy, 1);
    start = re_done;
    @(posedge clk); #1;
    start = 0;
    chk("post_done_busy", busy, 0);
    chk("post_done_pulse", done, 0);
    @(posedge clk); #1;
    chk("idle_after_done", {busy, out_valid}, 0);
  endtask

  task automatic wait_beat(input int g, input int r);
    int n = 0;
    while (!(grp_idx == g[1:0] && row_idx == r[RW-1:0] && out_valid) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 100) chk("wait_beat_timeout", 0, 1);
  endtask

  initial begin
    #12;
    chk_idle("reset");
    rst_n = 1;
    @(posedge clk); #1;
    chk_idle("after_release");

    run_pass(1'b0, 0, 0, 0);          // full pass
    run_pass(1'b1, 0, 0, 0);          // half-only pass
    run_pass(1'b0, 1, 0, 0);          // stalled pass
    run_pass(1'b0, 0, 1, 1);          // ignored starts
    run_pass(1'b1, 1, 0, 0);          // fresh pass after dropped starts

    // Async reset mid-quarter group.
    push_pass(1'b0);
    start = 1; half_only = 0; out_ready = 1;
    @(posedge clk); #1; start = 0;
    wait_beat(2, 1);
    #2 rst_n = 0;
    #1 chk_idle("async_reset");
    exp_q.delete();
    @(posedge clk); #1;
    chk("reset_no_done", done, 0);
    rst_n = 1;
    @(posedge clk); #1;
    run_pass(1'b0, 0, 0, 0);

`ifdef FME_SEQ_ABORT_EN
    push_pass(1'b0);
    start = 1; half_only = 0; out_ready = 1;
    @(posedge clk); #1; start = 0;
    wait_beat(1, 2);
    abort = 1;
    @(posedge clk); #1;
    abort = 0;
    exp_q.delete();
    chk_idle("abort");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("abort_no_done", {done, busy}, 0);
    end
    abort = 1; start = 1;
    @(posedge clk); #1;
    abort = 0; start = 0;
    chk("abort_beats_start", {busy, out_valid}, 0);
    @(posedge clk); #1;
    chk("abort_start_idle", busy, 0);
    run_pass(1'b1, 0, 0, 0);
`endif

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
